// File: rtl/aes_pkg.sv
// Shared AES definitions for the SubBytes/ShiftRows stage: S-box table,
// byte-position helpers, ShiftRows wiring and the stage FSM state type.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, SUB, HOLD} stateT;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Column-major packing: s[r][c] is byte 4c+r, byte 0 in the top bits.
  function automatic int byteIdx(int r, int c);
    return 4 * c + r;
  endfunction

  function automatic int byteRow(int k);
    return k % 4;
  endfunction

  function automatic int byteCol(int k);
    return k / 4;
  endfunction

  function automatic logic [7:0] getByte(logic [127:0] s, int k);
    return s[127 - 8 * k -: 8];
  endfunction

  function automatic logic [127:0] shift_rows(logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      o[127 - 8 * k -: 8] = getByte(s, byteIdx(byteRow(k), (byteCol(k) + byteRow(k)) % 4));
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single AES forward S-box as a combinational lookup into the shared table.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] x,
  output logic [7:0] y
);

  assign y = SBOX[x];

endmodule

// File: rtl/aes_sub_shift.sv
// Iterative SubBytes (LANES bytes per cycle) followed by a registered
// ShiftRows; one block in flight, result held until the consumer takes it.
module aes_sub_shift
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         out_last
);

  localparam int SUB_CYCLES = 16 / LANES;

  if (LANES != 4 && LANES != 8 && LANES != 16) begin : gBadLanes
    $error("aes_sub_shift: LANES must be 4, 8 or 16");
  end

  stateT        state, stateNext;
  logic [1:0]   grp;
  logic [127:0] work, workSub;
  logic         lastQ;
  logic         accept, lastGrp;
  logic [7:0]   laneIn  [LANES];
  logic [7:0]   laneOut [LANES];

  assign in_ready  = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == HOLD);
  assign lastGrp   = (grp == 2'(SUB_CYCLES - 1));

  for (genvar g = 0; g < LANES; g++) begin : gLane
    aes_sbox uSbox (.x(laneIn[g]), .y(laneOut[g]));
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      laneIn[l] = getByte(work, int'(grp) * LANES + l);
    end
  end

  // Substituted bytes are merged back in place over the current group.
  always_comb begin
    workSub = work;
    for (int l = 0; l < LANES; l++) begin
      workSub[127 - 8 * (int'(grp) * LANES + l) -: 8] = laneOut[l];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = SUB;
      SUB:     if (lastGrp) stateNext = HOLD;
      HOLD:    if (out_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grp       <= '0;
      work      <= '0;
      lastQ     <= 1'b0;
      out_state <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            work  <= in_state;
            lastQ <= in_last;
            grp   <= '0;
          end
        end
        SUB: begin
          work <= workSub;
          if (lastGrp) begin
            grp       <= '0;
            out_state <= shift_rows(workSub);
            out_last  <= lastQ;
          end else begin
            grp <= grp + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sub_shift.sv
// Bench for aes_sub_shift: directed vectors plus a GF(2^8) reference model,
// checked through a scoreboard on the LANES=4 instance.
module tb_aes_sub_shift;

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] ALL63    = {16{8'h63}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         inV [3];
  logic         inR [3];
  logic         inL [3];
  logic         oV  [3];
  logic         oR  [3];
  logic         oL  [3];
  logic [127:0] inS [3];
  logic [127:0] oS  [3];

  aes_sub_shift #(.LANES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(inV[0]), .in_ready(inR[0]), .in_state(inS[0]),
    .in_last(inL[0]), .out_valid(oV[0]), .out_ready(oR[0]), .out_state(oS[0]), .out_last(oL[0]));
  aes_sub_shift #(.LANES(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(inV[1]), .in_ready(inR[1]), .in_state(inS[1]),
    .in_last(inL[1]), .out_valid(oV[1]), .out_ready(oR[1]), .out_state(oS[1]), .out_last(oL[1]));
  aes_sub_shift #(.LANES(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(inV[2]), .in_ready(inR[2]), .in_state(inS[2]),
    .in_last(inL[2]), .out_valid(oV[2]), .out_ready(oR[2]), .out_state(oS[2]), .out_last(oL[2]));

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] st;
    logic         last;
  } expT;

  expT sb[$];
  int  nVec = 0;
  int  nErr = 0;
  int  nOut = 0;
  int  cyc  = 0;

  always @(posedge clk) cyc++;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sboxRef(logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 8'h00)
      for (int y = 1; y < 256; y++)
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] refSubShift(logic [127:0] s);
    logic [127:0] o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        int src = 4 * ((c + r) % 4) + r;
        o[127 - 8 * (4 * c + r) -: 8] = sboxRef(s[127 - 8 * src -: 8]);
      end
    return o;
  endfunction

  // Scoreboard monitor: a handshake happens on the next edge when both are high.
  always @(negedge clk) begin : monitor
    expT e;
    if (!rst && oV[0] && oR[0]) begin
      nOut++;
      if (sb.size() == 0) begin
        check("scoreboard_underflow", 128'(sb.size()), 128'd1);
      end else begin
        e = sb.pop_front();
        check("out_state", oS[0], e.st);
        check("out_last", 128'(oL[0]), 128'(e.last));
      end
    end
  end

  // Entered and left at posedge+1; returns in IDLE when out_ready is high.
  task automatic sendBlock(int d, logic [127:0] st, logic last, logic [127:0] expSt, int expLat);
    int lat = 0;
    check($sformatf("in_ready_before_accept_d%0d", d), 128'(inR[d]), 128'd1);
    inV[d] = 1'b1;
    inS[d] = st;
    inL[d] = last;
    if (d == 0) sb.push_back('{st: expSt, last: last});
    tick();
    inV[d] = 1'b0;
    inS[d] = ~st;
    inL[d] = ~last;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      tick();
      if (oV[d]) lat = i;
    end
    check($sformatf("latency_d%0d", d), 128'(lat), 128'(expLat));
    if (d != 0) begin
      check($sformatf("out_state_d%0d", d), oS[d], expSt);
      check($sformatf("out_last_d%0d", d), 128'(oL[d]), 128'(last));
    end
    if (oR[d]) tick();
  endtask

  initial begin
    int n0;
    int prev;
    logic [127:0] vec;
    for (int d = 0; d < 3; d++) begin
      inV[d] = 1'b0;
      inS[d] = '0;
      inL[d] = 1'b0;
      oR[d]  = 1'b1;
    end
    repeat (3) tick();
    check("rst_in_ready", 128'(inR[0]), 128'd0);
    check("rst_out_valid", 128'(oV[0]), 128'd0);
    check("rst_out_state", oS[0], 128'd0);
    check("rst_out_last", 128'(oL[0]), 128'd0);
    rst = 1'b0;
    tick();
    check("in_ready_after_rst", 128'(inR[0]), 128'd1);

    sendBlock(0, 128'd0, 1'b1, ALL63, 4);
    sendBlock(0, FIPS_IN, 1'b0, FIPS_OUT, 4);

    // Backpressure: result and flags frozen while the consumer stalls.
    oR[0] = 1'b0;
    sendBlock(0, FIPS_IN, 1'b1, FIPS_OUT, 4);
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", 128'(oV[0]), 128'd1);
      check("bp_out_state", oS[0], FIPS_OUT);
      check("bp_in_ready", 128'(inR[0]), 128'd0);
      inV[0] = i[0];
      tick();
    end
    inV[0] = 1'b0;
    oR[0]  = 1'b1;
    tick();
    check("bp_release_out_valid", 128'(oV[0]), 128'd0);
    check("bp_release_in_ready", 128'(inR[0]), 128'd1);

    // Busy: a different block is offered throughout SUB and HOLD.
    oR[0] = 1'b0;
    n0 = nOut;
    inV[0] = 1'b1;
    inS[0] = FIPS_IN;
    inL[0] = 1'b1;
    sb.push_back('{st: FIPS_OUT, last: 1'b1});
    tick();
    inS[0] = 128'd0;
    inL[0] = 1'b0;
    repeat (6) tick();
    check("busy_out_state", oS[0], FIPS_OUT);
    check("busy_out_last", 128'(oL[0]), 128'd1);
    inV[0] = 1'b0;
    oR[0]  = 1'b1;
    repeat (4) tick();
    check("busy_block_count", 128'(nOut - n0), 128'd1);

    // Reset while grp==2: nothing emitted, outputs cleared.
    n0 = nOut;
    inV[0] = 1'b1;
    inS[0] = FIPS_IN;
    inL[0] = 1'b1;
    tick();
    inV[0] = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst_out_valid", 128'(oV[0]), 128'd0);
    check("midrst_out_state", oS[0], 128'd0);
    check("midrst_in_ready", 128'(inR[0]), 128'd0);
    rst = 1'b0;
    tick();
    check("midrst_in_ready_after", 128'(inR[0]), 128'd1);
    check("midrst_no_output", 128'(nOut - n0), 128'd0);
    sendBlock(0, 128'd0, 1'b0, ALL63, 4);

    // Back-to-back with out_ready tied high; model-derived expectations.
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      vec = {$urandom, $urandom, $urandom, $urandom};
      inS[0] = vec;
      inL[0] = i[0];
      inV[0] = 1'b1;
      for (int w = 0; w < 20 && !inR[0]; w++) tick();
      sb.push_back('{st: refSubShift(vec), last: i[0]});
      tick();
      if (i > 0) check("b2b_accept_spacing", 128'(cyc - prev), 128'd6);
      prev = cyc;
    end
    inV[0] = 1'b0;
    for (int w = 0; w < 40 && sb.size() != 0; w++) tick();
    check("b2b_drained", 128'(sb.size()), 128'd0);

    sendBlock(1, FIPS_IN, 1'b1, FIPS_OUT, 2);
    sendBlock(2, FIPS_IN, 1'b0, FIPS_OUT, 1);
    sendBlock(2, 128'd0, 1'b1, ALL63, 1);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
